// File: rtl/universal_shift_register.sv
// Universal shift register: shift/rotate/ASR/load/clear with a per-word shift
// counter and a one-cycle word_done pulse after every WIDTH-th shift op.
module universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic [CW-1:0]    shift_count,
  output logic             word_done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_ROR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q, q_nxt;
  logic             so_q, so_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             done_q, done_nxt;
  logic             shift_op;

  // Next-state decode; anything not selected below holds.
  always_comb begin
    q_nxt    = q;
    so_nxt   = so_q;
    cnt_nxt  = cnt_q;
    done_nxt = 1'b0;
    shift_op = 1'b0;

    if (en) begin
      case (mode_e'(mode))
        MODE_HOLD: ;
        MODE_SHR: begin
          q_nxt    = {serial_in, q[WIDTH-1:1]};
          so_nxt   = q[0];
          shift_op = 1'b1;
        end
        MODE_SHL: begin
          q_nxt    = {q[WIDTH-2:0], serial_in};
          so_nxt   = q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_ROR: begin
          q_nxt    = {q[0], q[WIDTH-1:1]};
          so_nxt   = q[0];
          shift_op = 1'b1;
        end
        MODE_ROL: begin
          q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
          so_nxt   = q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_ASR: begin
          q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
          so_nxt   = q[0];
          shift_op = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt   = parallel_in;
          cnt_nxt = '0;
        end
        MODE_CLEAR: begin
          q_nxt   = '0;
          so_nxt  = 1'b0;
          cnt_nxt = '0;
        end
      endcase
    end

    // Every shift op counts regardless of direction; the WIDTH-th one closes the word.
    if (shift_op) begin
      if (cnt_q == CNT_LAST) begin
        cnt_nxt  = '0;
        done_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= '0;
      so_q   <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q      <= q_nxt;
      so_q   <= so_nxt;
      cnt_q  <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  assign parallel_out = q;
  assign serial_out   = so_q;
  assign shift_count  = cnt_q;
  assign word_done    = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register at WIDTH=8, 2 and 5 with
// hand-computed expectations checked by immediate assertions.
module tb_universal_shift_register;

  localparam logic [2:0] HOLD = 3'b000, SHR = 3'b001, SHL = 3'b010, ROR = 3'b011;
  localparam logic [2:0] ROL  = 3'b100, LOAD = 3'b101, ASR = 3'b110, CLR = 3'b111;
  localparam logic [2:0] ALL  = 3'b111;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] en_v;
  logic [2:0] mode;
  logic       si;
  logic [7:0] pin;

  logic [7:0] po8;  logic so8;  logic [2:0] cnt8;  logic wd8;
  logic [1:0] po2;  logic so2;  logic [0:0] cnt2;  logic wd2;
  logic [4:0] po5;  logic so5;  logic [2:0] cnt5;  logic wd5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en_v[0]), .mode(mode), .serial_in(si),
    .parallel_in(pin), .parallel_out(po8), .serial_out(so8),
    .shift_count(cnt8), .word_done(wd8));

  universal_shift_register #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .en(en_v[1]), .mode(mode), .serial_in(si),
    .parallel_in(pin[1:0]), .parallel_out(po2), .serial_out(so2),
    .shift_count(cnt2), .word_done(wd2));

  universal_shift_register #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(reset), .en(en_v[2]), .mode(mode), .serial_in(si),
    .parallel_in(pin[4:0]), .parallel_out(po5), .serial_out(so5),
    .shift_count(cnt5), .word_done(wd5));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one operation, clock it, sample 1ns after the edge.
  task automatic op(input logic [2:0] m, input logic [2:0] e, input logic s, input logic [7:0] p);
    mode = m; en_v = e; si = s; pin = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] so_seq;
    logic [2:0] mix [7];
    logic [1:0] v2;
    logic [4:0] v5;
    int pulses2, pulses5, pulses8, last8;

    reset = 1'b0; en_v = '0; mode = HOLD; si = 1'b0; pin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_po", 64'(po8), 64'h0);
    chk("rst_so", 64'(so8), 64'h0);
    chk("rst_cnt", 64'(cnt8), 64'h0);
    chk("rst_wd", 64'(wd8), 64'h0);
    reset = 1'b1;

    // Serialise 0xA5 out the LSB end.
    so_seq = 8'hA5;
    op(LOAD, ALL, 1'b0, 8'hA5);
    chk("ld_po", 64'(po8), 64'hA5);
    chk("ld_cnt", 64'(cnt8), 64'h0);
    for (int k = 1; k <= 8; k++) begin
      op(SHR, ALL, 1'b0, 8'h00);
      chk("ser_so", 64'(so8), 64'(so_seq[k-1]));
      chk("ser_po", 64'(po8), 64'(8'hA5 >> k));
      chk("ser_cnt", 64'(cnt8), 64'(k % 8));
      chk("ser_wd", 64'(wd8), 64'(k == 8));
    end
    op(HOLD, ALL, 1'b0, 8'h00);
    chk("ser_wd_after", 64'(wd8), 64'h0);
    chk("ser_cnt_after", 64'(cnt8), 64'h0);

    // Rotates and arithmetic shift.
    op(LOAD, ALL, 1'b0, 8'h81);
    op(ROL, ALL, 1'b0, 8'h00);
    chk("rol_po", 64'(po8), 64'h03);
    chk("rol_so", 64'(so8), 64'h1);
    op(LOAD, ALL, 1'b0, 8'h81);
    op(ROR, ALL, 1'b0, 8'h00);
    chk("ror_po", 64'(po8), 64'hC0);
    chk("ror_so", 64'(so8), 64'h1);
    op(LOAD, ALL, 1'b1, 8'h80);
    op(ASR, ALL, 1'b0, 8'h00);
    chk("asr_po", 64'(po8), 64'hC0);
    chk("asr_so", 64'(so8), 64'h0);
    chk("asr_cnt", 64'(cnt8), 64'h1);
    op(ROL, ALL, 1'b0, 8'h00);
    chk("rol2_po", 64'(po8), 64'h81);
    chk("rol2_so", 64'(so8), 64'h1);
    chk("rol2_cnt", 64'(cnt8), 64'h2);

    // Load keeps serial_out; en=0 holds everything.
    op(LOAD, ALL, 1'b0, 8'h3C);
    chk("ld3c_so", 64'(so8), 64'h1);
    chk("ld3c_cnt", 64'(cnt8), 64'h0);
    for (int k = 0; k < 5; k++) begin
      op(SHR, 3'b000, 1'b1, 8'hFF);
      chk("hold_po", 64'(po8), 64'h3C);
      chk("hold_so", 64'(so8), 64'h1);
      chk("hold_cnt", 64'(cnt8), 64'h0);
      chk("hold_wd", 64'(wd8), 64'h0);
    end
    op(ROR, ALL, 1'b0, 8'h00);
    op(CLR, 3'b000, 1'b0, 8'h00);
    chk("hold1_po", 64'(po8), 64'h1E);
    chk("hold1_cnt", 64'(cnt8), 64'h1);

    // Asynchronous reset in the middle of a word.
    op(LOAD, ALL, 1'b0, 8'hFF);
    for (int k = 0; k < 3; k++) op(SHL, ALL, 1'b0, 8'h00);
    chk("mid_po", 64'(po8), 64'hF8);
    chk("mid_cnt", 64'(cnt8), 64'h3);
    #2 reset = 1'b0;
    #1;
    chk("arst_po", 64'(po8), 64'h0);
    chk("arst_so", 64'(so8), 64'h0);
    chk("arst_cnt", 64'(cnt8), 64'h0);
    chk("arst_wd", 64'(wd8), 64'h0);
    #1 reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      op(SHL, ALL, 1'b1, 8'h00);
      chk("post_rst_po", 64'(po8), 64'((9'h1 << k) - 9'h1));
      chk("post_rst_cnt", 64'(cnt8), 64'(k % 8));
      chk("post_rst_wd", 64'(wd8), 64'(k == 8));
    end

    // Mixed-direction shifts, then load on the would-be 8th cycle.
    mix = '{SHR, SHL, ROR, ROL, ASR, SHR, SHL};
    for (int k = 0; k < 7; k++) begin
      op(mix[k], ALL, 1'b0, 8'h00);
      chk("mix_cnt", 64'(cnt8), 64'(k + 1));
    end
    op(LOAD, ALL, 1'b0, 8'h5A);
    chk("bnd_ld_wd", 64'(wd8), 64'h0);
    chk("bnd_ld_cnt", 64'(cnt8), 64'h0);
    chk("bnd_ld_po", 64'(po8), 64'h5A);
    pulses8 = 0; last8 = 0;
    for (int k = 1; k <= 16; k++) begin
      op(ROR, ALL, 1'b0, 8'h00);
      chk("b2b_wd", 64'(wd8), 64'((k == 8) || (k == 16)));
      chk("b2b_cnt", 64'(cnt8), 64'(k % 8));
      if (wd8) begin
        if (pulses8 > 0) chk("b2b_gap", 64'(k - last8), 64'd8);
        pulses8++; last8 = k;
      end
    end
    chk("b2b_po", 64'(po8), 64'h5A);
    chk("b2b_pulses", 64'(pulses8), 64'd2);
    op(HOLD, ALL, 1'b0, 8'h00);
    chk("b2b_wd_end", 64'(wd8), 64'h0);

    // Clear on the 8th cycle also suppresses word_done.
    for (int k = 0; k < 7; k++) op(SHL, ALL, 1'b1, 8'h00);
    op(CLR, ALL, 1'b1, 8'h00);
    chk("clr_po", 64'(po8), 64'h0);
    chk("clr_so", 64'(so8), 64'h0);
    chk("clr_cnt", 64'(cnt8), 64'h0);
    chk("clr_wd", 64'(wd8), 64'h0);

    // WIDTH=2 and WIDTH=5: serialise the low bits of 0xA5.
    v2 = 2'b01;
    v5 = 5'b00101;
    op(LOAD, ALL, 1'b0, 8'hA5);
    chk("w2_ld_po", 64'(po2), 64'h1);
    chk("w5_ld_po", 64'(po5), 64'h05);
    for (int k = 1; k <= 16; k++) begin
      op(SHR, ALL, 1'b0, 8'h00);
      if (k <= 2) begin
        chk("w2_so", 64'(so2), 64'(v2[k-1]));
        chk("w2_po", 64'(po2), 64'(v2 >> k));
      end
      if (k <= 5) begin
        chk("w5_so", 64'(so5), 64'(v5[k-1]));
        chk("w5_po", 64'(po5), 64'(v5 >> k));
      end
      chk("w2_cnt", 64'(cnt2), 64'(k % 2));
      chk("w2_wd", 64'(wd2), 64'((k % 2) == 0));
      chk("w5_cnt", 64'(cnt5), 64'(k % 5));
      chk("w5_wd", 64'(wd5), 64'((k % 5) == 0));
    end

    // Per-width boundary: load on the WIDTH-th cycle, then back-to-back shifts.
    op(CLR, ALL, 1'b0, 8'h00);
    op(SHL, 3'b010, 1'b1, 8'h00);
    op(LOAD, 3'b010, 1'b0, 8'h03);
    chk("w2_bnd_wd", 64'(wd2), 64'h0);
    chk("w2_bnd_cnt", 64'(cnt2), 64'h0);
    chk("w2_bnd_po", 64'(po2), 64'h3);
    for (int k = 0; k < 4; k++) op(SHL, 3'b100, 1'b1, 8'h00);
    chk("w5_pre_cnt", 64'(cnt5), 64'h4);
    op(LOAD, 3'b100, 1'b0, 8'h16);
    chk("w5_bnd_wd", 64'(wd5), 64'h0);
    chk("w5_bnd_cnt", 64'(cnt5), 64'h0);
    chk("w5_bnd_po", 64'(po5), 64'h16);
    pulses2 = 0; pulses5 = 0;
    for (int k = 1; k <= 16; k++) begin
      op(ROL, 3'b110, 1'b0, 8'h00);
      chk("w2_b2b_wd", 64'(wd2), 64'((k % 2) == 0));
      chk("w5_b2b_wd", 64'(wd5), 64'((k % 5) == 0));
      chk("w5_b2b_cnt", 64'(cnt5), 64'(k % 5));
      if (wd2) pulses2++;
      if (wd5) pulses5++;
    end
    chk("w2_pulses", 64'(pulses2), 64'd8);
    chk("w5_pulses", 64'(pulses5), 64'd3);
    chk("w5_rol_po", 64'(po5), 64'h0D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter CW, default $clog2(WIDTH), width of shift_count; not overridden by the instantiator.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 en  input  1  operation enable; 0 = hold all state.
REQ-006 mode  input  3  operation select, sampled when en=1.
REQ-007 serial_in  input  1  serial data entering the vacated end.
REQ-008 parallel_in  input  WIDTH  parallel load data.
REQ-009 parallel_out  output  WIDTH  register contents q.
REQ-010 serial_out  output  1  registered copy of the bit most recently shifted or rotated out.
REQ-011 shift_count  output  CW  shifts/rotates since last load, clear or wrap.
REQ-012 word_done  output  1  one-cycle pulse after the WIDTH-th shift of a word.

Function
REQ-013 mode decode when en=1 SHALL be:
- 000 hold
- 001 shift right
- 010 shift left
- 011 rotate right
- 100 rotate left
- 101 parallel load
- 110 arithmetic shift right
- 111 clear
REQ-014 Shift right: q <= {serial_in, q[WIDTH-1:1]}; serial_out <= q[0].
REQ-015 Shift left: q <= {q[WIDTH-2:0], serial_in}; serial_out <= q[WIDTH-1].
REQ-016 Rotate right: q <= {q[0], q[WIDTH-1:1]}; serial_out <= q[0]; serial_in ignored.
REQ-017 Rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; serial_out <= q[WIDTH-1]; serial_in ignored.
REQ-018 Arithmetic shift right: q <= {q[WIDTH-1], q[WIDTH-1:1]}; serial_out <= q[0]; serial_in ignored.
REQ-019 Parallel load: q <= parallel_in; shift_count <= 0; serial_out holds.
REQ-020 Clear: q <= 0; serial_out <= 0; shift_count <= 0.
REQ-021 Hold, or en=0 with any mode: q, serial_out and shift_count SHALL hold; word_done SHALL be 0 next cycle.
REQ-022 Modes 001/010/011/100/110 are "shift ops"; each one with en=1 SHALL increment shift_count by 1.
REQ-023 A shift op with shift_count = WIDTH-1 SHALL wrap shift_count to 0 and set word_done to 1 for exactly the following cycle.
REQ-024 word_done SHALL be registered; it SHALL be 0 in every cycle not covered by REQ-023.
REQ-025 Consecutive words: word_done SHALL pulse once per WIDTH shift ops with no idle cycle required between words.
REQ-026 Mixing shift directions within a word SHALL not affect counting; every shift op counts.
REQ-027 Load or clear issued in the cycle shift_count = WIDTH-1 SHALL reset the count and SHALL NOT pulse word_done.
REQ-028 parallel_out SHALL equal q combinationally from the register, with no additional latency.
REQ-029 All updates SHALL take effect one clock after the sampling edge; latency is 1 cycle for every mode.

Reset
REQ-030 While reset=0, the outputs SHALL immediately be, independent of clk: q=0, serial_out=0, shift_count=0, word_done=0.
REQ-031 Reset asserted mid-word SHALL discard the partial word; the first shift op after release counts as shift 1.
REQ-032 Reset deassertion SHALL be synchronised externally; the first edge after release SHALL perform the normal operation.

Verification
REQ-033 Serialise 0xA5 (WIDTH=8): load 0xA5, then 8 shift-right cycles, serial_in=0 -> serial_out sequence 1,0,1,0,0,1,0,1; parallel_out=0x00; word_done=1 only in the cycle after the 8th shift; shift_count=0.
REQ-034 Rotate/ASR (WIDTH=8):
- load 0x81, rotate left -> 0x03, serial_out=1
- load 0x81, rotate right -> 0xC0
- load 0x80, ASR -> 0xC0, serial_out=0
REQ-035 Hold: en=0 with mode=001 for 5 cycles after loading 0x3C -> parallel_out stays 0x3C; shift_count and serial_out unchanged; word_done=0.
REQ-036 Reset mid-word: 3 shift-left ops from 0xFF, then reset=0 between edges -> all outputs 0 before next edge; after release, 8 shift ops produce word_done on the 8th.
REQ-037 Boundary: 7 shifts, then load in 8th cycle -> no word_done, shift_count=0; then 16 back-to-back shifts -> exactly two word_done pulses, 8 cycles apart.
REQ-038 Parameter sweep: REQ-033 and REQ-037 repeated at WIDTH=2 and WIDTH=5 -> word_done every WIDTH shifts; shift_count never exceeds WIDTH-1.
